imem_loader: RTL and testbench

Boot-time writer for the instruction SRAM. It accepts a program as a byte stream with a valid/ready handshake and packs each group of 4 bytes into a 32-bit word. Each word is written into the instruction memory starting at the fetch start address. When the program is complete, the block pulses the PC register's asynchronous-load input so instruction fetch restarts at the first loaded instruction. It sits between the test/boot interface and the instruction memory's write port, and it owns the PC load signal.

---
 rtl/imem_loader_pkg.sv | 29 ++
 rtl/imem_loader_byte_packer.sv | 44 ++++
 rtl/imem_loader.sv | 168 ++++++++++++++++
 tb/tb_imem_loader.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: constants, state encoding and the address helper used by the
// instruction-memory loader. The default base address is the fetch start
// address, so fetch and the loader share this constant.
package imem_loader_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned CNT_W          = 16;

  localparam logic [WORD_W-1:0] DEFAULT_BASE_ADDR = 32'h0040_0020;
  localparam int unsigned       DEFAULT_MAX_WORDS = 1024;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_CHECK,
    S_RELEASE,
    S_DONE
  } state_t;

  // Byte address of word idx, wrapping modulo 2^32.
  function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] base,
                                                  input logic [CNT_W-1:0]  idx);
    return base + WORD_W'({idx, 2'b00});
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// imem_loader_byte_packer: packs a byte stream into big-endian words.
// Ports:
//   clk, reset  clock, async active-high reset
//   clear       restart the byte count (new load)
//   shift_en    a byte is accepted this cycle
//   data        accepted byte
//   word        combinational view of the word including the current byte
//   word_ready  combinational: the current byte completes a word
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] data,
  output logic [WORD_W-1:0] word,
  output logic              word_ready
);

  localparam int unsigned BCNT_W = $clog2(BYTES_PER_WORD);
  localparam int unsigned HOLD_W = BYTE_W * (BYTES_PER_WORD - 1);

  // Only the first three bytes are stored; the fourth is forwarded directly.
  logic [HOLD_W-1:0] hold;
  logic [BCNT_W-1:0] cnt;

  assign word       = {hold, data};
  assign word_ready = shift_en && (cnt == BCNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold <= '0;
      cnt  <= '0;
    end else if (clear) begin
      hold <= '0;
      cnt  <= '0;
    end else if (shift_en) begin
      hold <= {hold[HOLD_W-BYTE_W-1:0], data};
      cnt  <= cnt + BCNT_W'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction SRAM. Collects a byte
// stream into 32-bit words, writes them from BASE_ADDR upward, then pulses
// load_pc so fetch restarts at the first loaded instruction.
// Optional macro IMEM_LOADER_CHECKSUM_EN: XOR checksum of the written words is
// compared against 4 trailing bytes before load_pc is released.
// Ports:
//   clk, reset                 clock, async active-high reset
//   start, word_count          load request and program length in words
//   in_valid, in_data, in_ready  byte stream handshake
//   mem_cs, mem_we, mem_oe, mem_addr, mem_din  SRAM write port
//   load_pc                    one-cycle PC async-load pulse
//   busy, done, error          status
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [WORD_W-1:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned       MAX_WORDS = DEFAULT_MAX_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_cs,
  output logic              mem_we,
  output logic              mem_oe,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_din,
  output logic              load_pc,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  idx;
  logic [CNT_W-1:0]  idx_next_c;
  logic              accept_c;
  logic              start_ok_c;
  logic              len_bad_c;
  logic [WORD_W-1:0] word;
  logic              word_ready;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] sum;
`endif

  assign mem_oe     = 1'b0;
  assign accept_c   = in_valid && in_ready;
  assign idx_next_c = idx + CNT_W'(1);
  assign len_bad_c  = (word_count == '0) || (word_count > CNT_W'(MAX_WORDS));
  assign start_ok_c = start && !len_bad_c && ((state == S_IDLE) || (state == S_DONE));

  imem_loader_byte_packer u_byte_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok_c),
    .shift_en   (accept_c),
    .data       (in_data),
    .word       (word),
    .word_ready (word_ready)
  );

  // Control FSM; every output is set on the edge that enters its state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      count    <= '0;
      idx      <= '0;
      in_ready <= 1'b0;
      mem_cs   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      load_pc  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            done <= 1'b0;
            if (len_bad_c) begin
              error <= 1'b1;
              state <= S_IDLE;
            end else begin
              error    <= 1'b0;
              count    <= word_count;
              idx      <= '0;
              busy     <= 1'b1;
              in_ready <= 1'b1;
              state    <= S_COLLECT;
`ifdef IMEM_LOADER_CHECKSUM_EN
              sum      <= '0;
`endif
            end
          end
        end
        S_COLLECT: begin
          if (word_ready) begin
            in_ready <= 1'b0;
            mem_cs   <= 1'b1;
            mem_we   <= 1'b1;
            mem_addr <= word_addr(BASE_ADDR, idx);
            mem_din  <= word;
            state    <= S_WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum      <= sum ^ word;
`endif
          end
        end
        S_WRITE: begin
          mem_cs <= 1'b0;
          mem_we <= 1'b0;
          idx    <= idx_next_c;
          if (idx_next_c == count) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            in_ready <= 1'b1;
            state    <= S_CHECK;
`else
            load_pc  <= 1'b1;
            state    <= S_RELEASE;
`endif
          end else begin
            in_ready <= 1'b1;
            state    <= S_COLLECT;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (word_ready) begin
            in_ready <= 1'b0;
            if (word == sum) begin
              load_pc <= 1'b1;
              state   <= S_RELEASE;
            end else begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
`endif
        S_RELEASE: begin
          load_pc <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b1;
          state   <= S_DONE;
        end
        default: begin
          in_ready <= 1'b0;
          mem_cs   <= 1'b0;
          mem_we   <= 1'b0;
          load_pc  <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized loads checked against a word/address
// model derived from the byte stream.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0040_0020;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] word_count;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_cs;
  logic        mem_we;
  logic        mem_oe;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        load_pc;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pc_count = 0;
  int pc_cyc = 0;
  int bad_ctrl = 0;
  int start_cyc = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  prog[$];

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_cs     (mem_cs),
    .mem_we     (mem_we),
    .mem_oe     (mem_oe),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .load_pc    (load_pc),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every SRAM write and PC pulse seen mid-cycle.
  always @(negedge clk) begin
    if (mem_cs === 1'b1) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_din);
    end
    if (load_pc === 1'b1) begin
      pc_count = pc_count + 1;
      pc_cyc   = cyc;
    end
    if (mem_cs !== mem_we || mem_oe !== 1'b0) bad_ctrl = bad_ctrl + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, " mem_cs"},   32'(mem_cs),   32'd0);
    chk({tag, " mem_we"},   32'(mem_we),   32'd0);
    chk({tag, " mem_oe"},   32'(mem_oe),   32'd0);
    chk({tag, " load_pc"},  32'(load_pc),  32'd0);
    chk({tag, " busy"},     32'(busy),     32'd0);
    chk({tag, " done"},     32'(done),     32'd0);
    chk({tag, " error"},    32'(error),    32'd0);
    chk({tag, " mem_addr"}, mem_addr,      32'd0);
    chk({tag, " mem_din"},  mem_din,       32'd0);
  endtask

  // Called at a negedge; start is sampled on the following rising edge.
  task automatic do_start(input logic [15:0] n);
    start      = 1'b1;
    word_count = n;
    start_cyc  = cyc;
    @(negedge clk);
    start      = 1'b0;
    word_count = 16'($urandom);
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int tries;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    tries    = 0;
    while (in_ready !== 1'b1 && tries < 100) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 100) chk("in_ready timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  function automatic logic [31:0] model_word(input int i);
    return {prog[4*i], prog[4*i+1], prog[4*i+2], prog[4*i+3]};
  endfunction

  task automatic check_writes(input string tag, input int n);
    chk({tag, " write count"}, 32'(wr_addr.size()), 32'(n));
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      chk($sformatf("%s w%0d addr", tag, i), wr_addr[i], BASE + 32'(4 * i));
      chk($sformatf("%s w%0d data", tag, i), wr_data[i], model_word(i));
    end
  endtask

  // Full load of prog (4*n bytes); gap_at gets a 3-cycle stall, gap_max randomizes stalls.
  task automatic run_load(input string tag, input int n, input int gap_max,
                          input int gap_at, input bit bad_sum);
    int t;
    bit expect_ok;
    logic [31:0] sum;
    wr_addr.delete();
    wr_data.delete();
    pc_count = 0;
    do_start(16'(n));
    for (int i = 0; i < 4 * n; i++) begin
      send_byte(prog[i], (i == gap_at) ? 3 : ((gap_max == 0) ? 0 : int'($urandom_range(gap_max, 0))));
    end
    expect_ok = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum = 32'd0;
    for (int i = 0; i < n; i++) sum = sum ^ model_word(i);
    if (bad_sum) sum = sum ^ 32'h0000_0001;
    expect_ok = !bad_sum;
    send_byte(sum[31:24], 0);
    send_byte(sum[23:16], 0);
    send_byte(sum[15:8], 0);
    send_byte(sum[7:0], 0);
`else
    sum = 32'(bad_sum);
`endif
    t = 0;
    while (done !== 1'b1 && error !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " done"},    32'(done),  32'(expect_ok));
    chk({tag, " error"},   32'(error), 32'(!expect_ok));
    chk({tag, " busy"},    32'(busy),  32'd0);
    chk({tag, " load_pc pulses"}, 32'(pc_count), expect_ok ? 32'd1 : 32'd0);
    check_writes(tag, n);
`ifndef IMEM_LOADER_CHECKSUM_EN
    if (gap_max == 0 && gap_at < 0)
      chk({tag, " latency"}, 32'(pc_cyc - start_cyc), 32'(5 * n + 1));
`endif
  endtask

  task automatic fill_random(input int n);
    prog.delete();
    for (int i = 0; i < 4 * n; i++) prog.push_back(8'($urandom));
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    word_count = 16'd0;
    in_valid   = 1'b0;
    in_data    = 8'd0;
    repeat (2) @(negedge clk);
    chk_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);

    // Normal two-word program.
    prog = '{8'h3C, 8'h08, 8'h10, 8'h01, 8'h8D, 8'h09, 8'h00, 8'h04};
    run_load("normal", 2, 0, -1, 1'b0);
    chk("normal w0 literal", wr_data.size() > 0 ? wr_data[0] : 32'hx, 32'h3C08_1001);

    // Same program with in_valid dropped before byte 2.
    run_load("backpressure", 2, 0, 2, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    run_load("bad checksum", 2, 0, -1, 1'b1);
`endif

    // Illegal lengths: zero and MAX_WORDS + 1.
    wr_addr.delete();
    wr_data.delete();
    do_start(16'd0);
    @(negedge clk);
    chk("len0 error", 32'(error), 32'd1);
    chk("len0 busy",  32'(busy),  32'd0);
    chk("len0 done",  32'(done),  32'd0);
    chk("len0 in_ready", 32'(in_ready), 32'd0);
    do_start(16'd1025);
    repeat (3) @(negedge clk);
    chk("len1025 error", 32'(error), 32'd1);
    chk("len1025 busy",  32'(busy),  32'd0);
    chk("illegal writes", 32'(wr_addr.size()), 32'd0);

    // Reset after the first write of a three-word load.
    fill_random(3);
    wr_addr.delete();
    wr_data.delete();
    pc_count = 0;
    do_start(16'd3);
    for (int i = 0; i < 6; i++) send_byte(prog[i], 0);
    reset = 1'b1;
    #1;
    chk_reset_values("midreset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midreset writes", 32'(wr_addr.size()), 32'd1);
    chk("midreset w0 data", wr_data.size() > 0 ? wr_data[0] : 32'hx, model_word(0));
    chk("midreset load_pc", 32'(pc_count), 32'd0);
    fill_random(3);
    run_load("after reset", 3, 0, -1, 1'b0);

    // Start pulse during COLLECT must not change the captured count.
    fill_random(5);
    wr_addr.delete();
    wr_data.delete();
    pc_count = 0;
    do_start(16'd5);
    send_byte(prog[0], 0);
    send_byte(prog[1], 0);
    do_start(16'd2);
    for (int i = 2; i < 20; i++) send_byte(prog[i], 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    begin
      logic [31:0] s;
      s = 32'd0;
      for (int i = 0; i < 5; i++) s = s ^ model_word(i);
      send_byte(s[31:24], 0);
      send_byte(s[23:16], 0);
      send_byte(s[15:8], 0);
      send_byte(s[7:0], 0);
    end
`endif
    repeat (4) @(negedge clk);
    chk("busy-start done", 32'(done), 32'd1);
    chk("busy-start load_pc", 32'(pc_count), 32'd1);
    check_writes("busy-start", 5);

    // Randomized programs and stalls.
    for (int r = 0; r < 6; r++) begin
      int n;
      n = int'($urandom_range(8, 1));
      fill_random(n);
      run_load($sformatf("rand%0d", r), n, (r % 2 == 0) ? 0 : 2, -1, 1'b0);
    end

    chk("ctrl consistency", 32'(bad_ctrl), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
